// File: rtl/me_pkg.sv
// Shared types and constants for the motion-estimation best-match stage.
package me_pkg;

  localparam int DIST_W_DEF = 8;
  localparam int MV_W_DEF   = 4;

  // Saturated distortion value produced by the PE Accumulate stage.
  localparam logic [DIST_W_DEF-1:0] DIST_SAT = '1;

  typedef logic [MV_W_DEF-1:0] mv_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_e;

endpackage

// File: rtl/me_best_match_if.sv
// Candidate-distortion stream and best-match result bundle for me_best_match.
interface me_best_match_if #(
  parameter int DIST_W = 8,
  parameter int MV_W   = 4
);
  import me_pkg::*;

  // dist_valid/dist_in is a valid-only stream: there is no ready, the block
  // accepts every beat while SEARCH is active and silently drops beats otherwise.
  logic              start;
  logic              dist_valid;
  logic [DIST_W-1:0] dist_in;
  logic              busy;
  logic              done;
  logic              result_valid;
  logic [DIST_W-1:0] best_dist;
  logic [MV_W-1:0]   motion_x;
  logic [MV_W-1:0]   motion_y;
  state_e            dbg_state;

  modport slave (
    input  start, dist_valid, dist_in,
    output busy, done, result_valid, best_dist, motion_x, motion_y, dbg_state
  );

  modport master (
    output start, dist_valid, dist_in,
    input  busy, done, result_valid, best_dist, motion_x, motion_y, dbg_state
  );

endinterface

// File: rtl/me_raster_cnt.sv
// Raster-order (x,y) position counter over the search window.
module me_raster_cnt #(
  parameter int SEARCH_W = 16,
  parameter int SEARCH_H = 16,
  parameter int MV_W     = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  input  logic            advance,
  output logic [MV_W-1:0] x,
  output logic [MV_W-1:0] y,
  output logic            last
);

  localparam logic [MV_W-1:0] X_LAST = MV_W'(SEARCH_W - 1);
  localparam logic [MV_W-1:0] Y_LAST = MV_W'(SEARCH_H - 1);

  logic [MV_W-1:0] x_q, x_d;
  logic [MV_W-1:0] y_q, y_d;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (clear) begin
      x_d = '0;
      y_d = '0;
    end else if (advance) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        y_d = (y_q == Y_LAST) ? '0 : y_q + MV_W'(1);
      end else begin
        x_d = x_q + MV_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x    = x_q;
  assign y    = y_q;
  assign last = (x_q == X_LAST) && (y_q == Y_LAST);

endmodule

// File: rtl/me_best_match.sv
// Tracks the minimum SAD and its (x,y) position across a raster-scanned search window.
// Optional early exit on a perfect (zero) match is enabled by defining ME_ZERO_EXIT_EN.
module me_best_match
  import me_pkg::*;
#(
  parameter int SEARCH_W = 16,
  parameter int SEARCH_H = 16,
  parameter int DIST_W   = DIST_W_DEF,
  parameter int MV_W     = MV_W_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  me_best_match_if.slave  bus
);

  localparam logic [DIST_W-1:0] SAT = '1;

  state_e            state_q, state_d;
  logic [DIST_W-1:0] best_q, best_d;
  logic [MV_W-1:0]   mx_q, mx_d;
  logic [MV_W-1:0]   my_q, my_d;
  logic              first_q, first_d;
  logic              done_q, done_d;
  logic              rv_q, rv_d;

  logic              cnt_clear;
  logic              cnt_adv;
  logic              cnt_last;
  logic [MV_W-1:0]   cnt_x;
  logic [MV_W-1:0]   cnt_y;
  logic              take;
  logic              zero_hit;

  me_raster_cnt #(
    .SEARCH_W (SEARCH_W),
    .SEARCH_H (SEARCH_H),
    .MV_W     (MV_W)
  ) u_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (cnt_clear),
    .advance (cnt_adv),
    .x       (cnt_x),
    .y       (cnt_y),
    .last    (cnt_last)
  );

`ifdef ME_ZERO_EXIT_EN
  assign zero_hit = (bus.dist_in == '0);
`else
  assign zero_hit = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    best_d    = best_q;
    mx_d      = mx_q;
    my_d      = my_q;
    first_d   = first_q;
    done_d    = 1'b0;
    rv_d      = rv_q;
    cnt_clear = 1'b0;
    cnt_adv   = 1'b0;
    take      = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d   = SEARCH;
          cnt_clear = 1'b1;
          first_d   = 1'b1;
          rv_d      = 1'b0;
        end
      end

      SEARCH: begin
        // start wins over a coincident dist_valid: that beat belongs to the aborted scan.
        if (bus.start) begin
          cnt_clear = 1'b1;
          first_d   = 1'b1;
        end else if (bus.dist_valid) begin
          // Strict compare keeps the earliest raster position on ties.
          take    = first_q || (bus.dist_in < best_q);
          first_d = 1'b0;
          cnt_adv = 1'b1;
          if (take) begin
            best_d = bus.dist_in;
            mx_d   = cnt_x;
            my_d   = cnt_y;
          end
          if (cnt_last || zero_hit) begin
            state_d = DONE;
            done_d  = 1'b1;
            rv_d    = 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      best_q  <= SAT;
      mx_q    <= '0;
      my_q    <= '0;
      first_q <= 1'b0;
      done_q  <= 1'b0;
      rv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      best_q  <= best_d;
      mx_q    <= mx_d;
      my_q    <= my_d;
      first_q <= first_d;
      done_q  <= done_d;
      rv_q    <= rv_d;
    end
  end

  assign bus.busy         = (state_q == SEARCH);
  assign bus.done         = done_q;
  assign bus.result_valid = rv_q;
  assign bus.best_dist    = best_q;
  assign bus.motion_x     = mx_q;
  assign bus.motion_y     = my_q;
  assign bus.dbg_state    = state_q;

endmodule

// File: tb/tb_me_best_match.sv
// Self-checking bench for me_best_match on a 4x4 search window (either ME_ZERO_EXIT_EN build).
module tb_me_best_match;
  import me_pkg::*;

  localparam int SW = 4;
  localparam int SH = 4;
  localparam int DW = 8;
  localparam int MW = 2;
  localparam int N  = SW * SH;
  localparam int EW = DW + 2 * MW;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  me_best_match_if #(.DIST_W(DW), .MV_W(MW)) bus ();

  me_best_match #(
    .SEARCH_W (SW),
    .SEARCH_H (SH),
    .DIST_W   (DW),
    .MV_W     (MW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- scoreboard state ----------------
  logic [DW-1:0] win [N];
  logic [EW-1:0] exp_q [$];
  logic [DW-1:0] held_d;
  logic [MW-1:0] held_x;
  logic [MW-1:0] held_y;
  int n_cmp    = 0;
  int n_mis    = 0;
  int done_cnt = 0;

  always @(negedge clk) if (rst_n && bus.done) done_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  // Candidates the block should consume before finishing.
  function automatic int consumed_len();
`ifdef ME_ZERO_EXIT_EN
    for (int i = 0; i < N; i++) if (win[i] == '0) return i + 1;
`endif
    return N;
  endfunction

  // Minimum value first, then the earliest raster index holding it.
  function automatic logic [EW-1:0] model(input int n);
    int mn;
    int idx;
    mn = 256;
    for (int i = 0; i < n; i++) if (int'(win[i]) < mn) mn = int'(win[i]);
    idx = 0;
    for (int i = n - 1; i >= 0; i--) if (int'(win[i]) == mn) idx = i;
    return {DW'(mn), MW'(idx % SW), MW'(idx / SW)};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.dist_valid = 1'b0;
    bus.dist_in = '0;
    repeat (2) tick();
  endtask

  task automatic do_start(input bit with_valid);
    bus.start = 1'b1;
    bus.dist_valid = with_valid;
    bus.dist_in = '0;
    tick();
    bus.start = 1'b0;
    bus.dist_valid = 1'b0;
    check("start_busy", bus.busy, 1);
    check("start_rv", bus.result_valid, 0);
    check("start_done", bus.done, 0);
  endtask

  task automatic check_held(input string tag);
    check({tag, "_hold_done"}, bus.done, 0);
    check({tag, "_hold_rv"}, bus.result_valid, 1);
    check({tag, "_hold_busy"}, bus.busy, 0);
    check({tag, "_hold_dist"}, bus.best_dist, held_d);
    check({tag, "_hold_x"}, bus.motion_x, held_x);
    check({tag, "_hold_y"}, bus.motion_y, held_y);
  endtask

  // Feed the first n entries of win without completing the scan.
  task automatic feed_partial(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      bus.dist_valid = 1'b1;
      bus.dist_in = win[i];
      tick();
      bus.dist_valid = 1'b0;
      check({tag, "_busy"}, bus.busy, 1);
      check({tag, "_done"}, bus.done, 0);
    end
  endtask

  task automatic run_window(input int gap, input string tag);
    int n;
    int d0;
    logic [EW-1:0] e;
    n  = consumed_len();
    d0 = done_cnt;
    exp_q.push_back(model(n));
    for (int i = 0; i < N; i++) begin
      bus.dist_valid = 1'b1;
      bus.dist_in = win[i];
      tick();
      bus.dist_valid = 1'b0;
      if (i < n - 1) begin
        check({tag, "_busy"}, bus.busy, 1);
        check({tag, "_early_done"}, bus.done, 0);
      end else if (i == n - 1) begin
        e = exp_q.pop_front();
        {held_d, held_x, held_y} = e;
        check({tag, "_done"}, bus.done, 1);
        check({tag, "_rv"}, bus.result_valid, 1);
        check({tag, "_busy_off"}, bus.busy, 0);
        check({tag, "_dist"}, bus.best_dist, held_d);
        check({tag, "_x"}, bus.motion_x, held_x);
        check({tag, "_y"}, bus.motion_y, held_y);
      end else begin
        check_held({tag, "_post"});
      end
      for (int g = 0; g < gap; g++) begin
        tick();
        check({tag, "_gap_done"}, bus.done, 0);
      end
    end
    tick();
    check_held(tag);
    check({tag, "_pulses"}, done_cnt - d0, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [DW-1:0] sd;
    logic [MW-1:0] sx;
    logic [MW-1:0] sy;
    int d0;

    do_reset();
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_rv", bus.result_valid, 0);
    check("rst_dist", bus.best_dist, DIST_SAT);
    check("rst_x", bus.motion_x, 0);
    check("rst_y", bus.motion_y, 0);
    check("rst_state", bus.dbg_state, IDLE);
    rst_n = 1'b1;
    tick();

    // dist_valid in IDLE changes nothing
    for (int i = 0; i < 3; i++) begin
      bus.dist_valid = 1'b1;
      bus.dist_in = 8'h00;
      tick();
    end
    bus.dist_valid = 1'b0;
    check("idle_busy", bus.busy, 0);
    check("idle_dist", bus.best_dist, DIST_SAT);
    check("idle_rv", bus.result_valid, 0);

    // minimum found
    for (int i = 0; i < N; i++) win[i] = 8'h40;
    win[9] = 8'h05;
    do_start(0);
    run_window(0, "min");

    // dist_valid in DONE changes nothing
    for (int i = 0; i < 3; i++) begin
      bus.dist_valid = 1'b1;
      bus.dist_in = 8'h00;
      tick();
      bus.dist_valid = 1'b0;
      check_held("done_ign");
    end

    // all saturated, then ties
    for (int i = 0; i < N; i++) win[i] = 8'hFF;
    do_start(0);
    run_window(0, "sat");
    for (int i = 0; i < N; i++) win[i] = 8'h20;
    win[3]  = 8'h10;
    win[12] = 8'h10;
    do_start(0);
    run_window(0, "tie");

    // gapped vs gapless on the same window
    for (int i = 0; i < N; i++) win[i] = DW'($urandom_range(1, 255));
    do_start(0);
    run_window(5, "gap");
    sd = held_d; sx = held_x; sy = held_y;
    do_start(0);
    run_window(0, "nogap");
    check("gap_eq_dist", bus.best_dist, sd);
    check("gap_eq_x", bus.motion_x, sx);
    check("gap_eq_y", bus.motion_y, sy);

    // restart mid-search; the valid coincident with start is dropped
    d0 = done_cnt;
    for (int i = 0; i < N; i++) win[i] = DW'($urandom_range(16, 255));
    win[2] = 8'h01;
    do_start(0);
    feed_partial(7, "abort");
    do_start(1);
    for (int i = 0; i < N; i++) win[i] = DW'($urandom_range(9, 255));
    win[15] = 8'h08;
    run_window(0, "restart");
    check("restart_one_pulse", done_cnt - d0, 1);

    // reset mid-search
    d0 = done_cnt;
    for (int i = 0; i < N; i++) win[i] = DW'($urandom_range(0, 255));
    do_start(0);
    feed_partial(10, "midrst");
    rst_n = 1'b0;
    tick();
    check("midrst_busy", bus.busy, 0);
    check("midrst_done", bus.done, 0);
    check("midrst_rv", bus.result_valid, 0);
    check("midrst_dist", bus.best_dist, DIST_SAT);
    check("midrst_x", bus.motion_x, 0);
    check("midrst_y", bus.motion_y, 0);
    rst_n = 1'b1;
    tick();
    check("midrst_no_pulse", done_cnt - d0, 0);

    // zero candidate at index 5
    for (int i = 0; i < N; i++) win[i] = DW'($urandom_range(1, 255));
    win[5] = 8'h00;
    do_start(0);
    run_window(0, "zero");

    // randomized windows, narrow ranges force ties
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < N; i++)
        win[i] = (t % 2 == 0) ? DW'($urandom_range(0, 7)) : DW'($urandom_range(0, 255));
      do_start(0);
      run_window($urandom_range(0, 2), $sformatf("rnd%0d", t));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/me_best_match.md
Name: me_best_match

Overview:
- Downstream stage of the PE array in the motion estimator.
- Consumes one saturated 8-bit SAD distortion per candidate search position, in raster order.
- Tracks the minimum distortion and the (x,y) position that produced it.
- Reports the best motion vector once the whole search window has been scanned.

Parameters:
SEARCH_W, 16, candidate positions per row of the search window (>=2)
SEARCH_H, 16, candidate rows in the search window (>=2)
DIST_W, 8, distortion width; must match PE Accumulate width
MV_W, 4, width of each motion-vector coordinate; clog2(max(SEARCH_W,SEARCH_H))

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
start  input  1  begin a new search (single-cycle strobe)
dist_valid  input  1  dist_in holds the distortion for the current candidate
dist_in  input  DIST_W  candidate distortion (PE Accumulate; 8'hFF = saturated)
busy  output  1  search in progress
done  output  1  one-cycle pulse: result just became final
result_valid  output  1  level: best_dist/motion_x/motion_y are final
best_dist  output  DIST_W  minimum distortion so far
motion_x  output  MV_W  column index of best candidate
motion_y  output  MV_W  row index of best candidate

Behaviour:
- States: IDLE, SEARCH, DONE.
- Reset (rst_n low at clk edge): state IDLE; busy=0, done=0, result_valid=0; best_dist=all-ones; motion_x=motion_y=0; x/y counters=0.
- IDLE -> SEARCH on start.
  - Counters cleared; first-candidate flag set.
  - result_valid cleared.
- SEARCH, on each dist_valid:
  - Compare: the first candidate always loads. Otherwise load only if dist_in < best_dist (strict), so ties keep the earlier raster position.
  - Load means best_dist<=dist_in, motion_x<=x, motion_y<=y.
  - Counter update: x increments; at x==SEARCH_W-1, x wraps to 0 and y increments.
  - Last candidate is x==SEARCH_W-1 && y==SEARCH_H-1. On it, the compare/load still occurs and the next state is DONE.
- dist_valid low in SEARCH: hold all state; gaps of any length are allowed.
- Latency: after the clock edge that samples the last candidate, done=1 and result_valid=1 with final values in the same cycle.
- DONE:
  - done high for exactly one cycle; result_valid and outputs held until the next start.
  - start in DONE -> SEARCH; same clearing as from IDLE.
- start in SEARCH: abort and restart. Counters cleared and first flag set. A dist_valid in the same cycle is ignored; candidate 0 is the next valid.
- dist_valid in IDLE or DONE: ignored; no output change.
- busy=1 exactly in SEARCH.
- Saturated 8'hFF is an ordinary value. If all candidates are FF, the result is (0,0).
- Reset mid-search: immediate return to the reset values; no done pulse.

Optional Feature:
- Macro ME_ZERO_EXIT_EN.
- When defined: a candidate with dist_in==0 is loaded as best, and the block goes to DONE on that edge (perfect match, early exit). done pulses the next cycle; remaining candidates are not expected. Any further dist_valid is ignored.
- When undefined: zero is an ordinary value and the full window is always scanned.

Decomposition:
- Package me_pkg holds:
  - DIST_W default and DIST_SAT constant (all-ones).
  - State enum {IDLE, SEARCH, DONE}.
  - MV coordinate typedef.
- One natural sub-module: me_raster_cnt.
  - Interface: clear/advance inputs; x, y, last outputs.
  - Parameterised by SEARCH_W/SEARCH_H.

Test Plan (SEARCH_W=SEARCH_H=4 unless noted):
- Minimum found: reset, start, stream 16 values of 8'h40, with 8'h05 at index 9. Required: done pulses 1 cycle after the 16th valid; best_dist=05, motion_x=1, motion_y=2; result_valid held.
- Tie and saturation: all 16 = FF -> best_dist=FF, (0,0). Then restart with 8'h10 at indices 3 and 12, others 20 -> (3,0).
- Gaps and ignore: insert 5 idle cycles between valids; also assert dist_valid in IDLE and DONE. Required: result identical to a gapless run; IDLE/DONE valids change nothing.
- Restart mid-search: 7 valids with the min 01 at index 2, then start, then 16 valids with min 08 at index 15. Required: best_dist=08, (3,3); exactly one done pulse.
- Reset mid-search: drop rst_n after 10 valids. Required: next cycle busy=0, best_dist=FF, mv=(0,0), no done.
- ME_ZERO_EXIT_EN defined: dist 00 at index 5. Required: done 1 cycle later with (1,1); busy=0 thereafter. Macro undefined: all 16 candidates are consumed and done follows the 16th.
